c3lib_ckdiv_ratio_ctl_ctn: RTL and testbench
============================================

# c3lib_ckdiv_ratio_ctl_ctn

Sequencer that selects the divide ratio (/1, /2, /4, /8) of a three-stage cascaded DIV2 chain and switches between ratios glitch-free. Each switch follows the same order: gate the output clock, hold the divider stages in reset, change the mux select, release, wait for the chain to settle, ungate. It sits in the clock-network (ctn) layer between the configuration logic and the DIV2 chain, its output mux and its clock gate. Ratio changes are requested over a 4-phase req/ack handshake.

## Interface
Parameters:
- RESET_RATIO, 0: ratio code applied after reset (0=/1, 1=/2, 2=/4, 3=/8).
- GATE_CYC, 2: cycles the clock stays gated before the divider reset; legal range 1..255.
- SETTLE_CYC, 4: cycles between divider reset release and ungate; legal range 1..255.

Ports:
- clk_in  input  1  source clock; the sequencer and DIV2 stage 0 run on it.
- rst_n  input  1  reset rst_n, asynchronous, active-low.
- cfg_req  input  1  ratio-change request, 4-phase level.
- cfg_ratio  input  2  requested ratio code; sampled only when a request is accepted.
- cfg_ack  output  1  handshake acknowledge.
- div_rst_n  output  3  active-low reset per DIV2 stage; bit n drives stage n.
- sel_ratio  output  2  select for the output clock mux.
- clk_gate_en  output  1  enable for the output clock gate.
- cur_ratio  output  2  ratio currently in effect.
- busy  output  1  high in every state except IDLE.

## Operation
- All outputs are registered. Reset values: cfg_ack=0, div_rst_n=3'b000, sel_ratio=cur_ratio=RESET_RATIO, clk_gate_en=0, busy=1.
- FSM states: INIT_RST, GATE, RST, SETTLE, ACK, IDLE.
- After reset release the FSM is in INIT_RST. It stays there 2 cycles, then enters SETTLE (SETTLE_CYC cycles), then IDLE with clk_gate_en=1. No ack is generated for this start-up sequence.
- IDLE, cfg_req=1, cfg_ratio≠cur_ratio: latch cfg_ratio as the target, go to GATE, drive clk_gate_en=0.
- IDLE, cfg_req=1, cfg_ratio==cur_ratio: go directly to ACK. Gate and divider resets are not touched.
- GATE: hold GATE_CYC cycles, then go to RST. On entry to RST: div_rst_n=000, sel_ratio=cur_ratio=target.
- RST: hold 2 cycles, then go to SETTLE with div_rst_n=111.
- SETTLE: hold SETTLE_CYC cycles, then go to ACK. On entry to ACK: clk_gate_en=1, cfg_ack=1.
- ACK: cfg_ack stays 1 until cfg_req=0 is sampled. On that edge: cfg_ack=0, go to IDLE.
- cfg_req/cfg_ratio changes after acceptance are ignored until the FSM returns to IDLE.
- A new request can be accepted on the edge after IDLE is entered.
- One wait counter serves GATE and SETTLE. Width is 8 bits. It loads on state entry and counts down to 1. There is no wrap-around.
- Asserting rst_n mid-sequence aborts immediately and returns every output to its reset value. The latched target is discarded, and cur_ratio reverts to RESET_RATIO.

## Timing
- Request sampled at edge 0 for a ratio change:
  - edge 1: clk_gate_en=0.
  - edge 1+GATE_CYC: div_rst_n=000, sel_ratio updated.
  - edge 3+GATE_CYC: div_rst_n=111.
  - edge 3+GATE_CYC+SETTLE_CYC: cfg_ack=1, clk_gate_en=1.
  - Defaults give cfg_ack at edge 9.
- Same-ratio request: cfg_ack=1 at edge 1.
- cfg_ack falls on the first edge at which cfg_req=0 is sampled.
- clk_gate_en is never 1 while any div_rst_n bit is 0.
- sel_ratio changes only while clk_gate_en=0.

## Configuration
- C3LIB_CKDIV_CTL_STAGGER_EN defined:
  - Leaving RST, reset bits release one per cycle, stage 0 first (001, 011, 111).
  - SETTLE is entered only once all three bits are high.
  - Ratio-change latency grows by 2 cycles; default becomes 11.
  - INIT_RST follows the same staggered release.
- Not defined: all three bits release on the same edge, as described under Operation and Timing.

## Structure
- Package c3lib_ckdiv_ctl_pkg holds:
  - the state enum;
  - the ratio enum (RATIO_DIV1..RATIO_DIV8);
  - the localparam RST_HOLD_CYC=2.
- Sub-module c3lib_ckdiv_ctl_wait_cnt: loadable 8-bit down-counter with a done flag. The FSM instantiates it once.

## Test plan
- Reset release, RESET_RATIO=1 → clk_gate_en rises at edge 2+4=6, then IDLE; sel_ratio=1 throughout; cfg_ack stays 0.
- Request /1→/8 with defaults → gate low at edge 1, div_rst_n=000 at edge 3, sel_ratio=3 at edge 3, div_rst_n=111 at edge 5, cfg_ack and gate high at edge 9; ack drops one edge after req drops.
- Request for the current ratio → cfg_ack at edge 1; clk_gate_en and div_rst_n never toggle.
- cfg_ratio changed 2→0 during SETTLE → ignored; cur_ratio stays 2; ack timing unchanged.
- rst_n asserted in RST → all outputs at reset values immediately; restart follows the INIT_RST sequence; cur_ratio=RESET_RATIO.
- With C3LIB_CKDIV_CTL_STAGGER_EN → div_rst_n steps 001/011/111 on consecutive edges; cfg_ack at edge 11.

Source files
------------

// File: rtl/c3lib_ckdiv_ctl_pkg.sv
// Shared types and constants for the ckdiv ratio sequencer.
package c3lib_ckdiv_ctl_pkg;

  localparam int unsigned CNT_W        = 8;
  localparam int unsigned RATIO_W      = 2;
  localparam int unsigned NSTAGE       = 3;
  localparam int unsigned RST_HOLD_CYC = 2;

  typedef enum logic [2:0] {
    ST_INIT_RST,
    ST_GATE,
    ST_RST,
    ST_SETTLE,
    ST_ACK,
    ST_IDLE
  } state_e;

  typedef enum logic [RATIO_W-1:0] {
    RATIO_DIV1,
    RATIO_DIV2,
    RATIO_DIV4,
    RATIO_DIV8
  } ratio_e;

  // Next step of a staggered release: shift in one more deasserted stage reset.
  function automatic logic [NSTAGE-1:0] release_step(input logic [NSTAGE-1:0] cur);
    return {cur[NSTAGE-2:0], 1'b1};
  endfunction

endpackage

// File: rtl/c3lib_ckdiv_ctl_wait_cnt.sv
// Loadable down-counter that stops at 1; done_c flags the last cycle of a wait.
module c3lib_ckdiv_ctl_wait_cnt
  import c3lib_ckdiv_ctl_pkg::*;
#(
  parameter int unsigned RST_VAL = 1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= CNT_W'(RST_VAL);
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt > CNT_W'(1)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done_c = (cnt <= CNT_W'(1));

endmodule

// File: rtl/c3lib_ckdiv_ratio_ctl_ctn.sv
// Glitch-free divide-ratio sequencer for a 3-stage DIV2 chain (gate, reset, switch, settle, ungate).
// Define C3LIB_CKDIV_CTL_STAGGER_EN to release the stage resets one per cycle, stage 0 first.
module c3lib_ckdiv_ratio_ctl_ctn
  import c3lib_ckdiv_ctl_pkg::*;
#(
  parameter int unsigned RESET_RATIO = 0,
  parameter int unsigned GATE_CYC    = 2,
  parameter int unsigned SETTLE_CYC  = 4
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               cfg_req,
  input  logic [RATIO_W-1:0] cfg_ratio,
  output logic               cfg_ack,
  output logic [NSTAGE-1:0]  div_rst_n,
  output logic [RATIO_W-1:0] sel_ratio,
  output logic               clk_gate_en,
  output logic [RATIO_W-1:0] cur_ratio,
  output logic               busy
);

  localparam logic [CNT_W-1:0]   GATE_LD   = CNT_W'(GATE_CYC);
  localparam logic [CNT_W-1:0]   SETTLE_LD = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0]   HOLD_LD   = CNT_W'(RST_HOLD_CYC);
  localparam logic [RATIO_W-1:0] RST_RATIO = RATIO_W'(RESET_RATIO);

  state_e            state;
  ratio_e            target;
  logic              ack_pend;
  logic              cnt_done_c;
  logic              cnt_load_c;
  logic [CNT_W-1:0]  cnt_val_c;
  logic              req_chg_c;
  logic              rel_last_c;
  logic [NSTAGE-1:0] rel_next_c;

  assign req_chg_c = cfg_req && (cfg_ratio != cur_ratio);

`ifdef C3LIB_CKDIV_CTL_STAGGER_EN
  assign rel_next_c = release_step(div_rst_n);
  assign rel_last_c = (rel_next_c == {NSTAGE{1'b1}});
`else
  assign rel_next_c = {NSTAGE{1'b1}};
  assign rel_last_c = 1'b1;
`endif

  // Wait-counter load on entry to GATE, RST and SETTLE.
  always_comb begin
    cnt_load_c = 1'b0;
    cnt_val_c  = '0;
    case (state)
      ST_IDLE: begin
        if (req_chg_c) begin
          cnt_load_c = 1'b1;
          cnt_val_c  = GATE_LD;
        end
      end
      ST_GATE: begin
        if (cnt_done_c) begin
          cnt_load_c = 1'b1;
          cnt_val_c  = HOLD_LD;
        end
      end
      ST_INIT_RST, ST_RST: begin
        if (cnt_done_c && rel_last_c) begin
          cnt_load_c = 1'b1;
          cnt_val_c  = SETTLE_LD;
        end
      end
      default: ;
    endcase
  end

  c3lib_ckdiv_ctl_wait_cnt #(
    .RST_VAL (RST_HOLD_CYC)
  ) u_wait_cnt (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .load     (cnt_load_c),
    .load_val (cnt_val_c),
    .done_c   (cnt_done_c)
  );

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_INIT_RST;
      target      <= ratio_e'(RST_RATIO);
      ack_pend    <= 1'b0;
      cfg_ack     <= 1'b0;
      div_rst_n   <= '0;
      sel_ratio   <= RST_RATIO;
      cur_ratio   <= RST_RATIO;
      clk_gate_en <= 1'b0;
      busy        <= 1'b1;
    end else begin
      case (state)
        ST_INIT_RST, ST_RST: begin
          if (cnt_done_c) begin
            div_rst_n <= rel_next_c;
            if (rel_last_c) begin
              state <= ST_SETTLE;
            end
          end
        end
        ST_GATE: begin
          if (cnt_done_c) begin
            state     <= ST_RST;
            div_rst_n <= '0;
            sel_ratio <= target;
            cur_ratio <= target;
          end
        end
        ST_SETTLE: begin
          if (cnt_done_c) begin
            clk_gate_en <= 1'b1;
            ack_pend    <= 1'b0;
            // Start-up settle returns to IDLE without an acknowledge.
            if (ack_pend) begin
              state   <= ST_ACK;
              cfg_ack <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        ST_ACK: begin
          if (!cfg_req) begin
            state   <= ST_IDLE;
            cfg_ack <= 1'b0;
            busy    <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (cfg_req) begin
            busy <= 1'b1;
            if (req_chg_c) begin
              state       <= ST_GATE;
              target      <= ratio_e'(cfg_ratio);
              ack_pend    <= 1'b1;
              clk_gate_en <= 1'b0;
            end else begin
              state   <= ST_ACK;
              cfg_ack <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_INIT_RST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c3lib_ckdiv_ratio_ctl_ctn.sv
// Scoreboard bench for c3lib_ckdiv_ratio_ctl_ctn; honours C3LIB_CKDIV_CTL_STAGGER_EN.
module tb_c3lib_ckdiv_ratio_ctl_ctn;

  localparam int R = 1;
  localparam int G = 2;
  localparam int S = 4;
`ifdef C3LIB_CKDIV_CTL_STAGGER_EN
  localparam int STG = 2;
`else
  localparam int STG = 0;
`endif
  localparam int A       = 3 + G + STG + S;
  localparam int INIT_UP = 2 + STG + S;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b1;
  logic       cfg_req = 1'b0;
  logic [1:0] cfg_ratio = 2'd0;
  logic       cfg_ack;
  logic [2:0] div_rst_n;
  logic [1:0] sel_ratio;
  logic       clk_gate_en;
  logic [1:0] cur_ratio;
  logic       busy;

  c3lib_ckdiv_ratio_ctl_ctn #(
    .RESET_RATIO (R),
    .GATE_CYC    (G),
    .SETTLE_CYC  (S)
  ) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .cfg_req     (cfg_req),
    .cfg_ratio   (cfg_ratio),
    .cfg_ack     (cfg_ack),
    .div_rst_n   (div_rst_n),
    .sel_ratio   (sel_ratio),
    .clk_gate_en (clk_gate_en),
    .cur_ratio   (cur_ratio),
    .busy        (busy)
  );

  always #5 clk_in = ~clk_in;

  int cyc;
  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_chk = 0;
  int n_err = 0;
  int model_cur;

  typedef struct {
    int cyc;
    int ack;
    int rst;
    int sel;
    int gate;
    int cur;
    int busy;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic int rst_at(input int t, input int rel);
    if (t < rel) return 0;
    if (STG != 0) begin
      if (t == rel)     return 1;
      if (t == rel + 1) return 3;
    end
    return 7;
  endfunction

  task automatic push(input int c, input int ack, input int rst, input int sel,
                      input int gate, input int cur, input int bsy);
    exp_t e;
    e.cyc = c; e.ack = ack; e.rst = rst; e.sel = sel;
    e.gate = gate; e.cur = cur; e.busy = bsy;
    sb.push_back(e);
  endtask

  // Output monitor: pops the expectation for the current cycle and checks invariants.
  logic [1:0] prev_sel;
  always @(negedge clk_in) begin
    exp_t e;
    if (rst_n && clk_gate_en) check("gate_vs_rst", div_rst_n, 3'b111);
    if (rst_n && sel_ratio !== prev_sel) check("sel_while_gated", clk_gate_en, 0);
    prev_sel = sel_ratio;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      check("sb_missed", e.cyc, cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      check("cfg_ack",     cfg_ack,     e.ack);
      check("div_rst_n",   div_rst_n,   e.rst);
      check("sel_ratio",   sel_ratio,   e.sel);
      check("clk_gate_en", clk_gate_en, e.gate);
      check("cur_ratio",   cur_ratio,   e.cur);
      check("busy",        busy,        e.busy);
    end
  end

  task automatic step();
    @(negedge clk_in);
    #1;
  endtask

  task automatic check_reset_vals();
    check("rst_cfg_ack",   cfg_ack,     0);
    check("rst_div_rst_n", div_rst_n,   0);
    check("rst_sel_ratio", sel_ratio,   R);
    check("rst_gate",      clk_gate_en, 0);
    check("rst_cur_ratio", cur_ratio,   R);
    check("rst_busy",      busy,        1);
  endtask

  // Release reset and expect the start-up sequence with no acknowledge.
  task automatic init_seq();
    step();
    check_reset_vals();
    rst_n = 1'b1;
    for (int k = 1; k <= INIT_UP + 1; k++)
      push(k, 0, rst_at(k, 2), R, (k >= INIT_UP) ? 1 : 0, R, (k < INIT_UP) ? 1 : 0);
    repeat (INIT_UP + 2) step();
    model_cur = R;
  endtask

  // One request; alt>=0 changes cfg_ratio mid-SETTLE, abort_t>0 asserts rst_n at that cycle.
  task automatic run_req(input int to, input int alt, input int abort_t);
    int c0;
    int last;
    int rs;
    c0 = cyc;
    cfg_req = 1'b1;
    cfg_ratio = 2'(to);
    if (to != model_cur) begin
      last = (abort_t > 0) ? abort_t : A + 1;
      for (int t = 1; t <= last; t++) begin
        rs = (t < 1 + G) ? 7 : rst_at(t, 3 + G);
        push(c0 + t, (t == A) ? 1 : 0, rs, (t < 1 + G) ? model_cur : to,
             (t >= A) ? 1 : 0, (t < 1 + G) ? model_cur : to, (t <= A) ? 1 : 0);
      end
      for (int t = 1; t <= last; t++) begin
        step();
        if (t == abort_t) begin
          rst_n = 1'b0;
          cfg_req = 1'b0;
          #1;
          check_reset_vals();
        end
        if (t == A) cfg_req = 1'b0;
        if (alt >= 0 && t == 3 + G + STG + 1) cfg_ratio = 2'(alt);
      end
      if (abort_t > 0) init_seq();
      else             model_cur = to;
    end else begin
      push(c0 + 1, 1, 7, model_cur, 1, model_cur, 1);
      push(c0 + 2, 0, 7, model_cur, 1, model_cur, 0);
      step();
      cfg_req = 1'b0;
      step();
    end
    repeat (2) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    model_cur = R;
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    prev_sel = sel_ratio;
    init_seq();
    run_req(0, -1, 0);
    run_req(3, -1, 0);
    run_req(3, -1, 0);
    run_req(2, 0, 0);
    run_req(0, -1, 1 + G);
    run_req(3, -1, 0);
    run_req(1, -1, 0);
    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    check("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
